neuron_integrator: RTL and testbench
====================================

Name: neuron_integrator

Overview:
- Sequential membrane-potential update engine for one neuron slot in a RANC core.
- On `start`, walks all axons one per cycle and accumulates the selected synaptic weight into the potential with saturation, then applies leak and the threshold/fire/reset decision.
- Sits between the core controller/CSRAM read path and the neuron write-back and spike router.
- The signed saturating add is the arithmetic heart of the block.

Parameters:
- NUM_AXONS, 256, axons scanned per update (power of two, ≥2).
- NUM_WEIGHTS, 4, distinct axon types/weights.
- DATA_WIDTH, 9, signed membrane potential width.
- WEIGHT_WIDTH, 9, signed weight/leak width (≤ DATA_WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- start  input  1  begin an update; accepted only while idle.
- axon_spikes  input  NUM_AXONS  current-tick axon spike vector.
- synapses  input  NUM_AXONS  this neuron's connectivity row.
- axon_types  input  NUM_AXONS*log2(NUM_WEIGHTS)  packed per-axon type, axon 0 in LSBs.
- weights  input  NUM_WEIGHTS*WEIGHT_WIDTH  packed signed weights, type 0 in LSBs.
- potential_in  input  DATA_WIDTH  signed starting potential.
- leak  input  WEIGHT_WIDTH  signed leak, added once.
- threshold  input  DATA_WIDTH  signed firing threshold.
- reset_potential  input  DATA_WIDTH  signed value loaded on fire.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle completion pulse.
- spike_out  output  1  fire result; valid when done=1, held until next acceptance.
- potential_out  output  DATA_WIDTH  updated potential; valid with done, held.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; busy, done, spike_out = 0; potential_out = 0; index and accumulator = 0. A reset mid-update aborts the update. No done is issued, and the block accepts start on the first cycle after rst returns high.
- FSM states: IDLE, INTEGRATE, LEAK, FIRE.
- IDLE:
  - start=1 → INTEGRATE.
  - On that edge: latch active = axon_spikes & synapses; accumulator = potential_in; index = 0; spike_out = 0.
- INTEGRATE, one axon per cycle:
  - If active[index], accumulator = sat(accumulator + weights[axon_types[index]]); otherwise it is unchanged.
  - index increments each cycle.
  - After index = NUM_AXONS-1 is processed → LEAK. The counter wraps to 0 and must not overrun.
- LEAK: accumulator = sat(accumulator + leak) → FIRE.
- FIRE:
  - If accumulator ≥ threshold (signed): spike_out = 1 and potential_out = reset_potential.
  - Otherwise spike_out = 0 and potential_out = accumulator.
  - done = 1 for this single cycle; next state IDLE.
- Latency: start accepted at edge T; done is high in the cycle following edge T+NUM_AXONS+2. busy is high for exactly NUM_AXONS+2 cycles.
- sat(): sign-extend both operands to DATA_WIDTH+1, add, then clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Saturation is applied every step, not only at the end.
- start while busy or during the done cycle is ignored: no restart, no queuing.
- axon_types, weights, leak, threshold and reset_potential must be held stable by the upstream controller while busy. axon_spikes and synapses may change after acceptance.
- Back-to-back updates: start may be asserted in the cycle after done, giving one idle cycle between updates.

Decomposition:
- Shared package `ranc_neuron_pkg`:
  - state enum {IDLE, INTEGRATE, LEAK, FIRE};
  - TYPE_WIDTH = log2(NUM_WEIGHTS);
  - helper functions for signed max/min of a given width.
- One sub-module, `saturating_accumulate`: purely combinational signed DATA_WIDTH + WEIGHT_WIDTH add with clamp. It is shared by the INTEGRATE and LEAK steps through an operand mux, so there is exactly one instance.

Test Plan:
- No active axons (synapses=0), potential_in=5, leak=-1, threshold=10 → done exactly NUM_AXONS+3 cycles after the start edge; potential_out=4, spike_out=0.
- All axons active, all type 0, weight[0]=1, potential_in=0, leak=0, threshold=255, reset_potential=0 → positive saturation at 255; spike_out=1, potential_out=0.
- 10 active axons of type 1, weight[1]=-100, potential_in=-200, leak=0, threshold=10 → clamp at -256; spike_out=0, potential_out=-256.
- 3 active axons, weights 2/3/5 by type, potential_in=0, leak=0, threshold=10 → sum equals threshold; spike_out=1, potential_out=reset_potential.
- start re-pulsed at cycles 5 and NUM_AXONS+2 of an update → exactly one done, with a result identical to the unperturbed run.
- rst driven low at index 100 for 1 cycle → busy=0, potential_out=0, no done; a fresh start then yields the correct result.

Source files
------------

// File: rtl/neuron_integrator_pkg.sv
// Shared definitions for the RANC neuron integrator.
//   state_t          : update-sequencer states (IDLE, INTEGRATE, LEAK, FIRE)
//   TYPE_WIDTH       : bits per axon type for the default 4-weight configuration
//   signed_max/min() : extreme values of a two's-complement number of a given width
package ranc_neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INTEGRATE,
        LEAK,
        FIRE
    } state_t;

    localparam int NUM_WEIGHTS_DEFAULT = 4;
    localparam int TYPE_WIDTH          = $clog2(NUM_WEIGHTS_DEFAULT);

    function automatic int signed_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int signed_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/neuron_integrator_if.sv
// Bundle of the controller-facing signals of the neuron integrator.
//   master : upstream core controller (drives start and operands, reads results)
//   slave  : the integrator itself
// Operands: start, axon_spikes, synapses, axon_types, weights, potential_in,
//           leak, threshold, reset_potential.
// Results : busy, done, spike_out, potential_out.
interface neuron_integrator_if #(
    parameter int NUM_AXONS    = 256,
    parameter int NUM_WEIGHTS  = 4,
    parameter int DATA_WIDTH   = 9,
    parameter int WEIGHT_WIDTH = 9
);
    localparam int TYPE_W = $clog2(NUM_WEIGHTS);

    logic                                  start;
    logic        [NUM_AXONS-1:0]           axon_spikes;
    logic        [NUM_AXONS-1:0]           synapses;
    logic        [NUM_AXONS*TYPE_W-1:0]    axon_types;
    logic        [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] weights;
    logic signed [DATA_WIDTH-1:0]          potential_in;
    logic signed [WEIGHT_WIDTH-1:0]        leak;
    logic signed [DATA_WIDTH-1:0]          threshold;
    logic signed [DATA_WIDTH-1:0]          reset_potential;
    logic                                  busy;
    logic                                  done;
    logic                                  spike_out;
    logic signed [DATA_WIDTH-1:0]          potential_out;

    modport master (
        output start, axon_spikes, synapses, axon_types, weights,
               potential_in, leak, threshold, reset_potential,
        input  busy, done, spike_out, potential_out
    );

    modport slave (
        input  start, axon_spikes, synapses, axon_types, weights,
               potential_in, leak, threshold, reset_potential,
        output busy, done, spike_out, potential_out
    );

endinterface

// File: rtl/neuron_integrator_saturating_accumulate.sv
// Combinational signed saturating add: sum = clamp(acc + addend).
//   acc    : DATA_WIDTH signed running value
//   addend : WEIGHT_WIDTH signed increment (weight or leak)
//   sum    : DATA_WIDTH signed result, clamped to the representable range
module saturating_accumulate
    import ranc_neuron_pkg::*;
#(
    parameter int DATA_WIDTH   = 9,
    parameter int WEIGHT_WIDTH = 9
) (
    input  logic signed [DATA_WIDTH-1:0]   acc,
    input  logic signed [WEIGHT_WIDTH-1:0] addend,
    output logic signed [DATA_WIDTH-1:0]   sum
);
    localparam logic signed [DATA_WIDTH:0] MAX_EXT = (DATA_WIDTH+1)'(signed_max(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH:0] MIN_EXT = (DATA_WIDTH+1)'(signed_min(DATA_WIDTH));

    logic signed [DATA_WIDTH:0] acc_ext;
    logic signed [DATA_WIDTH:0] addend_ext;
    logic signed [DATA_WIDTH:0] sum_ext;

    // One guard bit is enough: the sum of two DATA_WIDTH-range values
    // always fits in DATA_WIDTH+1 bits.
    assign acc_ext    = {acc[DATA_WIDTH-1], acc};
    assign addend_ext = {{(DATA_WIDTH-WEIGHT_WIDTH+1){addend[WEIGHT_WIDTH-1]}}, addend};
    assign sum_ext    = acc_ext + addend_ext;

    always_comb begin
        sum = sum_ext[DATA_WIDTH-1:0];
        if (sum_ext > MAX_EXT) begin
            sum = MAX_EXT[DATA_WIDTH-1:0];
        end else if (sum_ext < MIN_EXT) begin
            sum = MIN_EXT[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/neuron_integrator.sv
// Membrane-potential update engine for one neuron slot.
// On an accepted start, scans every axon (one per cycle), adds the typed
// weight of each active axon with saturation, adds the leak once, then
// compares against the threshold and produces spike/potential results.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : neuron_integrator_if.slave (operands in, busy/done/results out)
module neuron_integrator
    import ranc_neuron_pkg::*;
#(
    parameter int NUM_AXONS    = 256,
    parameter int NUM_WEIGHTS  = 4,
    parameter int DATA_WIDTH   = 9,
    parameter int WEIGHT_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    neuron_integrator_if.slave   bus
);
    localparam int TYPE_W  = $clog2(NUM_WEIGHTS);
    localparam int INDEX_W = $clog2(NUM_AXONS);
    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NUM_AXONS - 1);

    state_t                         state_reg;
    state_t                         state_next;
    logic                           accept;
    logic        [NUM_AXONS-1:0]    active_reg;
    logic        [INDEX_W-1:0]      index_reg;
    logic signed [DATA_WIDTH-1:0]   acc_reg;
    logic                           done_reg;
    logic                           spike_reg;
    logic signed [DATA_WIDTH-1:0]   potential_reg;

    // Unpacked views of the packed weight and type vectors.
    logic signed [WEIGHT_WIDTH-1:0] weight_array [NUM_WEIGHTS];
    logic        [TYPE_W-1:0]       type_array   [NUM_AXONS];

    for (genvar gi = 0; gi < NUM_WEIGHTS; gi++) begin : g_weights
        assign weight_array[gi] = bus.weights[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    for (genvar gi = 0; gi < NUM_AXONS; gi++) begin : g_types
        assign type_array[gi] = bus.axon_types[gi*TYPE_W +: TYPE_W];
    end

    // Single adder shared between the per-axon weight and the leak step.
    logic signed [WEIGHT_WIDTH-1:0] addend;
    logic signed [DATA_WIDTH-1:0]   sum;

    assign addend = (state_reg == LEAK) ? bus.leak : weight_array[type_array[index_reg]];

    saturating_accumulate #(
        .DATA_WIDTH   (DATA_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_sat_acc (
        .acc    (acc_reg),
        .addend (addend),
        .sum    (sum)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A start seen during the done cycle is dropped so a
    // controller holding start high cannot retrigger on stale operands.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start && !done_reg) begin
                    accept     = 1'b1;
                    state_next = INTEGRATE;
                end
            end
            INTEGRATE: begin
                if (index_reg == LAST_INDEX) begin
                    state_next = LEAK;
                end
            end
            LEAK:    state_next = FIRE;
            FIRE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active_reg    <= '0;
            index_reg     <= '0;
            acc_reg       <= '0;
            done_reg      <= 1'b0;
            spike_reg     <= 1'b0;
            potential_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        // Spikes/synapses may change after acceptance, so the
                        // active mask is captured here.
                        active_reg <= bus.axon_spikes & bus.synapses;
                        acc_reg    <= bus.potential_in;
                        index_reg  <= '0;
                        spike_reg  <= 1'b0;
                    end
                end
                INTEGRATE: begin
                    if (active_reg[index_reg]) begin
                        acc_reg <= sum;
                    end
                    // Wraps to zero after the last axon.
                    index_reg <= index_reg + INDEX_W'(1);
                end
                LEAK: begin
                    acc_reg <= sum;
                end
                FIRE: begin
                    done_reg <= 1'b1;
                    if (acc_reg >= bus.threshold) begin
                        spike_reg     <= 1'b1;
                        potential_reg <= bus.reset_potential;
                    end else begin
                        spike_reg     <= 1'b0;
                        potential_reg <= acc_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy          = (state_reg != IDLE);
    assign bus.done          = done_reg;
    assign bus.spike_out     = spike_reg;
    assign bus.potential_out = potential_reg;

endmodule

// File: tb/tb_neuron_integrator.sv
module tb_neuron_integrator;
    import ranc_neuron_pkg::*;

    localparam int NA = 256;
    localparam int NW = 4;
    localparam int DW = 9;
    localparam int WW = 9;
    localparam int TW = $clog2(NW);

    typedef struct {
        logic spike;
        int   pot;
        int   done_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    exp_t exp_q [$];
    exp_t cur;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_integrator_if #(.NUM_AXONS(NA), .NUM_WEIGHTS(NW), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) bus ();

    neuron_integrator #(.NUM_AXONS(NA), .NUM_WEIGHTS(NW), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("spike_out", int'(bus.spike_out), int'(cur.spike));
                    check("potential_out", int'(bus.potential_out), cur.pot);
                    check("done_latency", cyc, cur.done_edge);
                    check("busy_cycles", busy_cnt, NA + 2);
                    $display("done #%0d at edge %0d: spike=%0d potential=%0d",
                             done_cnt, cyc, bus.spike_out, bus.potential_out);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
        bus.weights[0*WW +: WW] = WW'(w0);
        bus.weights[1*WW +: WW] = WW'(w1);
        bus.weights[2*WW +: WW] = WW'(w2);
        bus.weights[3*WW +: WW] = WW'(w3);
    endtask

    task automatic set_all_types(input int t);
        for (int i = 0; i < NA; i++) bus.axon_types[i*TW +: TW] = TW'(t);
    endtask

    task automatic set_params(input int pin, input int lk, input int thr, input int rp);
        bus.potential_in    = DW'(pin);
        bus.leak            = WW'(lk);
        bus.threshold       = DW'(thr);
        bus.reset_potential = DW'(rp);
    endtask

    // Issue start; optionally record the expected result and done edge.
    task automatic issue_start(input bit expect_result, input logic sp, input int pot);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (expect_result) exp_q.push_back('{sp, pot, cyc + NA + 2});
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 2 * NA && done_cnt < target; i++) begin
            @(posedge clk);
            #2;
        end
        check("done_count", done_cnt, target);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.axon_spikes = '0;
        bus.synapses    = '0;
        bus.axon_types  = '0;
        bus.weights     = '0;
        set_params(0, 0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_spike", int'(bus.spike_out), 0);
        check("reset_potential", int'(bus.potential_out), 0);
        @(negedge clk);
        rst = 1'b1;

        // 1: no active axons, leak only: 5 - 1 = 4 < 10
        bus.axon_spikes = '1;
        bus.synapses    = '0;
        set_all_types(0);
        set_weights(1, 1, 1, 1);
        set_params(5, -1, 10, 0);
        issue_start(1'b1, 1'b0, 4);
        wait_done(1);

        // 2: 256 x (+1) saturates at 255 >= 255 -> fire, reset to 0 (back-to-back)
        bus.synapses = '1;
        set_params(0, 0, 255, 0);
        issue_start(1'b1, 1'b1, 0);
        wait_done(2);

        // 3: -200 + 10 x (-100) clamps at -256
        bus.synapses = '0;
        for (int i = 10; i < 20; i++) bus.synapses[i] = 1'b1;
        set_all_types(1);
        set_weights(0, -100, 0, 0);
        set_params(-200, 0, 10, 5);
        issue_start(1'b1, 1'b0, -256);
        wait_done(3);

        // 4: 2 + 3 + 5 = 10 equals threshold -> fire, potential = reset_potential
        bus.synapses = '0;
        bus.synapses[2:0] = 3'b111;
        set_all_types(3);
        bus.axon_types[0*TW +: TW] = TW'(0);
        bus.axon_types[1*TW +: TW] = TW'(1);
        bus.axon_types[2*TW +: TW] = TW'(2);
        set_weights(2, 3, 5, 100);
        set_params(0, 0, 10, -7);
        issue_start(1'b1, 1'b1, -7);
        wait_done(4);

        // 5: same as 4, with start re-pulsed mid-update, in FIRE and in the
        //    done cycle, and spikes/synapses cleared after acceptance
        issue_start(1'b1, 1'b1, -7);
        bus.axon_spikes = '0;
        bus.synapses    = '0;
        for (int k = 1; k <= NA + 3; k++) begin
            @(negedge clk);
            bus.start = (k == 5 || k == NA + 2 || k == NA + 3);
            @(posedge clk);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("single_done_after_repulse", done_cnt, 5);

        // 6: leak saturation -250 - 10 -> -256, threshold -256 -> fire
        set_params(-250, -10, -256, 3);
        issue_start(1'b1, 1'b1, 3);
        wait_done(6);

        // 7: reset at index 100 aborts the update
        bus.axon_spikes = '1;
        bus.synapses    = '1;
        set_all_types(0);
        set_weights(1, 1, 1, 1);
        set_params(0, 0, 300, 0);
        issue_start(1'b0, 1'b0, 0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_spike", int'(bus.spike_out), 0);
        check("abort_potential", int'(bus.potential_out), 0);
        repeat (NA + 10) @(posedge clk);
        #2;
        check("no_done_after_abort", done_cnt, 6);

        // 8: fresh update after abort (repeat of case 1)
        bus.synapses = '0;
        set_params(5, -1, 10, 0);
        issue_start(1'b1, 1'b0, 4);
        wait_done(7);

        repeat (4) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
